// File: rtl/pipelined_instruction_memory.sv
// Word-organised instruction store with a req/gnt/rvalid fetch port and a loader write port.
// Fetches are read at the acceptance edge and then carried through a LATENCY-deep response pipe.
module pipelined_instruction_memory #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int DEPTH           = 256,
   parameter int LATENCY         = 1,
   parameter int GNT_WAIT        = 0,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_i,
   input  logic [ADDR_WIDTH-1:0]    addr_i,
   output logic                     gnt_o,
   output logic                     rvalid_o,
   output logic [DATA_WIDTH-1:0]    rdata_o,
   output logic                     err_o,
   input  logic                     ld_we_i,
   input  logic [$clog2(DEPTH)-1:0] ld_addr_i,
   input  logic [DATA_WIDTH-1:0]    ld_wdata_i
);

   localparam int OFF_W = $clog2(DATA_WIDTH / 8);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int OST_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int WT_W  = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] word_idx;
   logic [IDX_W-1:0]      mem_idx;
   logic                  in_range;
   logic [DATA_WIDTH-1:0] rd_word;

   logic [WT_W-1:0]       wait_q, wait_d;
   logic [OST_W-1:0]      ost_q, ost_d;
   logic                  wait_ok;
   logic                  can_issue;
   logic                  retire;
   logic                  accept;

   logic                  pipe_v_q [LATENCY];
   logic [DATA_WIDTH-1:0] pipe_d_q [LATENCY];
   logic                  pipe_e_q [LATENCY];

   // The loader port has no reset so preloaded code survives rst_n.
   always_ff @(posedge clk) begin
      if (ld_we_i) begin
         mem_q[ld_addr_i] <= ld_wdata_i;
      end
   end

   assign word_idx = addr_i >> OFF_W;
   assign mem_idx  = word_idx[IDX_W-1:0];
   assign in_range = (word_idx < ADDR_WIDTH'(DEPTH));
   assign rd_word  = in_range ? mem_q[mem_idx] : '0;

   assign retire    = pipe_v_q[LATENCY-1];
   assign wait_ok   = (wait_q == WT_W'(GNT_WAIT));
   assign can_issue = (ost_q < OST_W'(MAX_OUTSTANDING)) || retire;
   // Gated by rst_n so no grant is seen while the counters are held cleared.
   assign accept    = rst_n && req_i && wait_ok && can_issue;
   assign gnt_o     = accept;

   always_comb begin
      wait_d = wait_q;
      if (!req_i || accept) begin
         wait_d = '0;
      end else if (!wait_ok) begin
         wait_d = wait_q + WT_W'(1);
      end
   end

   always_comb begin
      ost_d = ost_q;
      case ({accept, retire})
         2'b10:   ost_d = ost_q + OST_W'(1);
         2'b01:   ost_d = ost_q - OST_W'(1);
         default: ost_d = ost_q;
      endcase
   end

   // Idle stages carry zero data so rdata_o/err_o are 0 whenever rvalid_o is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LATENCY; i++) begin
            pipe_v_q[i] <= 1'b0;
            pipe_d_q[i] <= '0;
            pipe_e_q[i] <= 1'b0;
         end
         wait_q <= '0;
         ost_q  <= '0;
      end else begin
         pipe_v_q[0] <= accept;
         pipe_d_q[0] <= accept ? rd_word : '0;
         pipe_e_q[0] <= accept && !in_range;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_v_q[i] <= pipe_v_q[i-1];
            pipe_d_q[i] <= pipe_d_q[i-1];
            pipe_e_q[i] <= pipe_e_q[i-1];
         end
         wait_q <= wait_d;
         ost_q  <= ost_d;
      end
   end

   assign rvalid_o = pipe_v_q[LATENCY-1];
   assign rdata_o  = pipe_d_q[LATENCY-1];
   assign err_o    = pipe_e_q[LATENCY-1];

endmodule

// File: tb/tb_pipelined_instruction_memory.sv
// Bench for pipelined_instruction_memory: four parameterisations share one stimulus stream
// and are checked every cycle against a schedule-based reference model, plus directed sequences.
module tb_pipelined_instruction_memory;

   localparam int NI   = 4;
   localparam int LAT [NI] = '{1, 3, 1, 2};
   localparam int GW  [NI] = '{0, 0, 2, 1};
   localparam int MOS [NI] = '{2, 2, 2, 1};
   localparam int NCYC = 4096;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req = 1'b0;
   logic [31:0] addr = '0;
   logic        ld_we = 1'b0;
   logic [7:0]  ld_addr = '0;
   logic [31:0] ld_wdata = '0;

   logic        gnt    [NI];
   logic        rvalid [NI];
   logic [31:0] rdata  [NI];
   logic        err    [NI];

   always #5 clk = ~clk;

   pipelined_instruction_memory #(.LATENCY(1), .GNT_WAIT(0), .MAX_OUTSTANDING(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .req_i(req), .addr_i(addr), .gnt_o(gnt[0]),
      .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
      .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata));

   pipelined_instruction_memory #(.LATENCY(3), .GNT_WAIT(0), .MAX_OUTSTANDING(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .req_i(req), .addr_i(addr), .gnt_o(gnt[1]),
      .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
      .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata));

   pipelined_instruction_memory #(.LATENCY(1), .GNT_WAIT(2), .MAX_OUTSTANDING(2)) dut_c (
      .clk(clk), .rst_n(rst_n), .req_i(req), .addr_i(addr), .gnt_o(gnt[2]),
      .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]),
      .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata));

   pipelined_instruction_memory #(.LATENCY(2), .GNT_WAIT(1), .MAX_OUTSTANDING(1)) dut_d (
      .clk(clk), .rst_n(rst_n), .req_i(req), .addr_i(addr), .gnt_o(gnt[3]),
      .rvalid_o(rvalid[3]), .rdata_o(rdata[3]), .err_o(err[3]),
      .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata));

   // Reference model: responses are scheduled by absolute cycle number.
   bit          ev [NI][NCYC];
   logic [31:0] ed [NI][NCYC];
   bit          ee [NI][NCYC];
   int          outst  [NI];
   int          hold   [NI];
   bit          last_g [NI];
   logic [31:0] mem [256];
   int          cyc   = 0;
   int          total = 0;
   int          bad   = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   function automatic logic [31:0] pv(input int w);
      if (w == 1) return 32'hDEADBEEF;
      if (w == 5) return 32'h0000_0011;
      return {8'hA5, 8'(w), 16'(w * 7 + 3)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   // One clock cycle: compare all instances at the falling edge, then advance the model.
   task automatic step();
      bit          g [NI];
      bit          v;
      logic [31:0] widx;
      logic [31:0] rd;
      bit          oor;
      if (cyc >= NCYC - 8) begin
         $display("FAIL cycle_budget cyc=%0d got=%0d want<%0d", cyc, cyc, NCYC - 8);
         $fatal(1, "cycle budget exhausted");
      end
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         g[k] = rst_n && req && (hold[k] >= GW[k]) && ((outst[k] < MOS[k]) || ev[k][cyc]);
         v    = rst_n && ev[k][cyc];
         chk($sformatf("gnt%0d", k),    32'(gnt[k]),    32'(g[k]));
         chk($sformatf("rvalid%0d", k), 32'(rvalid[k]), 32'(v));
         chk($sformatf("rdata%0d", k),  rdata[k],       v ? ed[k][cyc] : 32'h0);
         chk($sformatf("err%0d", k),    32'(err[k]),    32'(v && ee[k][cyc]));
      end
      @(posedge clk);
      widx = addr >> 2;
      oor  = (widx >= 32'd256);
      rd   = oor ? 32'h0 : mem[widx[7:0]];
      for (int k = 0; k < NI; k++) begin
         if (!rst_n) begin
            outst[k] = 0;
            hold[k]  = 0;
            for (int j = cyc + 1; j <= cyc + 4; j++) ev[k][j] = 1'b0;
         end else begin
            if (ev[k][cyc]) outst[k]--;
            if (g[k]) begin
               ev[k][cyc + LAT[k]] = 1'b1;
               ed[k][cyc + LAT[k]] = rd;
               ee[k][cyc + LAT[k]] = oor;
               outst[k]++;
               hold[k] = 0;
            end else if (req) begin
               hold[k]++;
            end else begin
               hold[k] = 0;
            end
         end
         last_g[k] = g[k];
      end
      if (ld_we) mem[ld_addr] = ld_wdata;
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      req = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      vec_t tbl [7];
      bit   b_gnt [7];
      bit   b_rv  [7];
      logic [31:0] b_rd [7];
      bit   c_req [9];
      bit   c_gnt [9];

      tbl[0] = '{32'h0000_0004, 32'hDEADBEEF, 1'b0};
      tbl[1] = '{32'h0000_0007, 32'hDEADBEEF, 1'b0};
      tbl[2] = '{32'h88C3_2008, 32'h0,        1'b1};
      tbl[3] = '{32'h0000_03FC, pv(255),      1'b0};
      tbl[4] = '{32'h0000_0400, 32'h0,        1'b1};
      tbl[5] = '{32'h0000_0000, pv(0),        1'b0};
      tbl[6] = '{32'h0000_0016, 32'h11,       1'b0};

      b_gnt = '{1, 1, 0, 1, 0, 0, 0};
      b_rv  = '{0, 0, 0, 1, 1, 0, 1};
      b_rd  = '{32'h0, 32'h0, 32'h0, pv(0), 32'hDEADBEEF, 32'h0, pv(2)};
      c_req = '{1, 1, 1, 0, 1, 0, 1, 1, 1};
      c_gnt = '{0, 0, 1, 0, 0, 0, 0, 0, 1};

      // Reset state with a request pending.
      #1 rst_n = 1'b0;
      req = 1'b1;
      #2;
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("rst_gnt%0d", k),    32'(gnt[k]),    32'h0);
         chk($sformatf("rst_rvalid%0d", k), 32'(rvalid[k]), 32'h0);
         chk($sformatf("rst_rdata%0d", k),  rdata[k],       32'h0);
         chk($sformatf("rst_err%0d", k),    32'(err[k]),    32'h0);
      end
      step();
      step();
      rst_n = 1'b1;
      req   = 1'b0;

      for (int w = 0; w < 256; w++) begin
         ld_we = 1'b1;
         ld_addr = 8'(w);
         ld_wdata = pv(w);
         step();
      end
      ld_we = 1'b0;
      idle(4);

      // Single fetches on the default instance.
      for (int i = 0; i < 7; i++) begin
         req  = 1'b1;
         addr = tbl[i].addr;
         #1;
         chk($sformatf("tbl%0d_gnt", i), 32'(gnt[0]), 32'h1);
         step();
         req = 1'b0;
         chk($sformatf("tbl%0d_rvalid", i), 32'(rvalid[0]), 32'h1);
         chk($sformatf("tbl%0d_rdata", i),  rdata[0],       tbl[i].rdata);
         chk($sformatf("tbl%0d_err", i),    32'(err[0]),    32'(tbl[i].err));
         idle(3);
      end

      // Read during load: same-edge fetch sees old data, later fetch sees new.
      req = 1'b1; addr = 32'h14;
      ld_we = 1'b1; ld_addr = 8'd5; ld_wdata = 32'h22;
      #1;
      chk("rdl_gnt", 32'(gnt[0]), 32'h1);
      step();
      req = 1'b0; ld_we = 1'b0;
      chk("rdl_old", rdata[0], 32'h11);
      step();
      req = 1'b1;
      step();
      req = 1'b0;
      chk("rdl_new", rdata[0], 32'h22);
      idle(4);

      // LATENCY=3, MAX_OUTSTANDING=2 back-pressure.
      for (int c = 0; c < 7; c++) begin
         req  = (c < 4);
         addr = (c == 0) ? 32'h0 : (c == 1) ? 32'h4 : 32'h8;
         #1;
         chk($sformatf("ost_gnt_c%0d", c),    32'(gnt[1]),    32'(b_gnt[c]));
         chk($sformatf("ost_rvalid_c%0d", c), 32'(rvalid[1]), 32'(b_rv[c]));
         chk($sformatf("ost_rdata_c%0d", c),  rdata[1],       b_rd[c]);
         step();
      end
      idle(4);

      // GNT_WAIT=2 counting and restart after req drops.
      addr = 32'h8;
      for (int c = 0; c < 9; c++) begin
         req = c_req[c];
         #1;
         chk($sformatf("gw_gnt_c%0d", c), 32'(gnt[2]), 32'(c_gnt[c]));
         step();
      end
      idle(4);

      // Reset with two fetches in flight on the LATENCY=3 instance.
      req = 1'b1; addr = 32'h4;
      #1;
      chk("rmf_gnt0", 32'(gnt[1]), 32'h1);
      step();
      addr = 32'h8;
      #1;
      chk("rmf_gnt1", 32'(gnt[1]), 32'h1);
      step();
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < NI; k++) chk($sformatf("rmf_rst_gnt%0d", k), 32'(gnt[k]), 32'h0);
      step();
      rst_n = 1'b1;
      req   = 1'b0;
      for (int c = 0; c < 6; c++) begin
         chk($sformatf("rmf_dropped_c%0d", c), 32'(rvalid[1]), 32'h0);
         step();
      end
      req = 1'b1; addr = 32'h4;
      step();
      req = 1'b0;
      chk("rmf_retained", rdata[0], 32'hDEADBEEF);
      idle(4);

      // Randomised traffic with loads and occasional resets.
      for (int n = 0; n < 1400; n++) begin
         bit allg;
         allg = last_g[0] && last_g[1] && last_g[2] && last_g[3];
         if (!req || allg) begin
            addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1100));
         end
         req      = ($urandom_range(0, 9) < 7);
         ld_we    = ($urandom_range(0, 4) == 0);
         ld_addr  = 8'($urandom_range(0, 255));
         ld_wdata = $urandom;
         rst_n    = ($urandom_range(0, 99) != 0);
         step();
      end
      rst_n = 1'b1;
      ld_we = 1'b0;
      idle(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
